rename_map: RTL

Parametrised register renamer with a free list, release path and flush. It sits between the pending queue and dispatch. Each dequeued instruction receives a physical tag for its writeback register, and its two sources are looked up against the newest live mapping. Physical entries are returned to the free pool on retire, or all at once on a pipeline flush.

---
 rtl/rename_pkg.sv | 27 ++
 rtl/rename_map_first_free.sv | 20 ++
 rtl/rename_map.sv | 114 +++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared sizing constants and width helpers for the register renamer.
package rename_pkg;

  localparam int ARCH_REGS_DEF = 16;
  localparam int PHYS_REGS_DEF = 32;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A lookup result carries the physical tag plus one mapped flag above it.
  function automatic int tag_w(input int pw);
    return pw + 1;
  endfunction

  // The mapped flag sits directly above the physical tag bits.
  function automatic int mapped_bit(input int pw);
    return pw;
  endfunction

  localparam int AW_DEF         = addr_w(ARCH_REGS_DEF);
  localparam int PW_DEF         = addr_w(PHYS_REGS_DEF);
  localparam int TW_DEF         = tag_w(PW_DEF);
  localparam int MAPPED_BIT_DEF = mapped_bit(PW_DEF);

endpackage

// File: rtl/rename_map_first_free.sv
// Lowest-set-bit priority encoder used to pick the next free physical entry.
module first_free #(
  parameter  int N  = 32,
  localparam int IW = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  free_vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx = '0;
    any = |free_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rename_map.sv
// Register renamer: allocates physical tags, tracks the newest mapping per
// architectural register, and returns entries on release or flush.
module rename_map
  import rename_pkg::*;
#(
  parameter  int ARCH_REGS = ARCH_REGS_DEF,
  parameter  int PHYS_REGS = PHYS_REGS_DEF,
  localparam int AW        = addr_w(ARCH_REGS),
  localparam int PW        = addr_w(PHYS_REGS),
  localparam int TW        = tag_w(PW)
) (
  input  logic          clk,
  input  logic          notrst,
  input  logic          alloc_req,
  input  logic [AW-1:0] alloc_nr,
  output logic          alloc_gnt,
  output logic [PW-1:0] alloc_tag,
  input  logic [AW-1:0] nr_a,
  input  logic [AW-1:0] nr_b,
  output logic [TW-1:0] tag_a,
  output logic [TW-1:0] tag_b,
  input  logic          rel_valid,
  input  logic [PW-1:0] rel_tag,
  input  logic          flush,
  output logic [TW-1:0] free_count,
  output logic          full
);

  localparam int MB = mapped_bit(PW);

  logic [PHYS_REGS-1:0] using_q;
  logic [PHYS_REGS-1:0] latest_q;
  logic [PHYS_REGS-1:0] match_a;
  logic [PHYS_REGS-1:0] match_b;
  logic [PW-1:0]        ff_idx;
  logic                 ff_any;

  // Highest matching index wins if the one-hot invariant is ever broken.
  function automatic logic [TW-1:0] encode_hit(input logic [PHYS_REGS-1:0] match);
    logic [PHYS_REGS-1:0] above;
    logic [PHYS_REGS-1:0] onehot;
    logic [TW-1:0]        res;
    above[PHYS_REGS-1] = 1'b0;
    for (int i = PHYS_REGS - 2; i >= 0; i--) above[i] = above[i+1] | match[i+1];
    onehot = match & ~above;
    res = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      if (onehot[i]) res[PW-1:0] = res[PW-1:0] | PW'(i);
    end
    res[MB] = |match;
    return res;
  endfunction

  first_free #(.N(PHYS_REGS)) u_first_free (
    .free_vec (~using_q),
    .idx      (ff_idx),
    .any      (ff_any)
  );

  assign full      = ~ff_any;
  assign alloc_tag = ff_idx;
  assign alloc_gnt = alloc_req & ~full & ~flush;
  assign tag_a     = encode_hit(match_a);
  assign tag_b     = encode_hit(match_b);

  // Free entries are counted directly from the allocation bits.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      free_count = free_count + TW'(~using_q[i]);
    end
  end

  for (genvar i = 0; i < PHYS_REGS; i++) begin : g_entry
    logic          using_r;
    logic          latest_r;
    logic [AW-1:0] nrs_r;
    logic          take;
    logic          supersede;
    logic          release_hit;

    assign take        = alloc_gnt & (ff_idx == PW'(i));
    assign supersede   = alloc_gnt & latest_r & (nrs_r == alloc_nr);
    assign release_hit = rel_valid & using_r & (rel_tag == PW'(i));

    assign using_q[i]  = using_r;
    assign latest_q[i] = latest_r;
    assign match_a[i]  = using_r & latest_r & (nrs_r == nr_a);
    assign match_b[i]  = using_r & latest_r & (nrs_r == nr_b);

    // Entry update: flush clears all, otherwise allocate, supersede or release.
    always_ff @(posedge clk or negedge notrst) begin
      if (!notrst) begin
        using_r  <= 1'b0;
        latest_r <= 1'b0;
        nrs_r    <= '0;
      end else if (flush) begin
        using_r  <= 1'b0;
        latest_r <= 1'b0;
      end else if (take) begin
        using_r  <= 1'b1;
        latest_r <= 1'b1;
        nrs_r    <= alloc_nr;
      end else begin
        if (supersede) latest_r <= 1'b0;
        if (release_hit) begin
          using_r  <= 1'b0;
          latest_r <= 1'b0;
        end
      end
    end
  end

endmodule
